// File: rtl/cache_xfer_pkg.sv
// rtl/cache_xfer_pkg.sv - shared state and request-op encodings for the cache line transfer engine
//
// Contents:
//   xfer_state_t : controller states (IDLE, WB, FILL, DONE)
//   xfer_op_t    : req_op encodings (fill, writeback, writeback-then-fill, illegal)

package cache_xfer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } xfer_state_t;

    typedef enum logic [1:0] {
        OP_FILL    = 2'b00,
        OP_WB      = 2'b01,
        OP_WB_FILL = 2'b10,
        OP_ILLEGAL = 2'b11
    } xfer_op_t;

endpackage

// File: rtl/cache_line_xfer.sv
// rtl/cache_line_xfer.sv - moves one cache line between a line buffer and a word-wide memory bus
//
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   req_valid/req_ready         : request handshake (ready only while idle)
//   req_op                      : 00 fill, 01 writeback, 10 writeback-then-fill, 11 illegal
//   req_wb_addr, req_fill_addr  : byte addresses, aligned down to the line inside the block
//   req_wb_line                 : line to write back, word 0 in the LSBs
//   busy, done, err             : status; done pulses one cycle, err qualifies done
//   fill_line                   : line assembled from read beats
//   mem_req/mem_we/mem_addr/
//   mem_wd/mem_mask             : word-level memory request
//   mem_wait, mem_rd            : memory stall and read data (sampled on completed beats)

module cache_line_xfer
    import cache_xfer_pkg::*;
#(
    parameter int WORDS  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic [1:0]              req_op,
    input  logic [ADDR_W-1:0]       req_wb_addr,
    input  logic [ADDR_W-1:0]       req_fill_addr,
    input  logic [WORDS*DATA_W-1:0] req_wb_line,
    output logic                    req_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [WORDS*DATA_W-1:0] fill_line,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wd,
    output logic [DATA_W/8-1:0]     mem_mask,
    input  logic                    mem_wait,
    input  logic [DATA_W-1:0]       mem_rd
);

    localparam int BYTES_PER_WORD = DATA_W / 8;
    localparam int LINE_BYTES     = WORDS * BYTES_PER_WORD;
    localparam int WORD_SHIFT     = $clog2(BYTES_PER_WORD);
    localparam int KW             = $clog2(WORDS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BYTES - 1);
    localparam logic [KW-1:0]     LAST_K    = KW'(WORDS - 1);

    xfer_state_t             state;
    xfer_op_t                op_q;
    logic [KW-1:0]           k;
    logic [KW-1:0]           k_next;
    logic                    last_beat;
    logic                    beat_done;
    logic [ADDR_W-1:0]       wb_base;
    logic [ADDR_W-1:0]       fill_base;
    logic [WORDS*DATA_W-1:0] wb_line;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return a & ~LINE_MASK;
    endfunction

    // Byte offset of word idx within the line; the add that uses it wraps
    // naturally at the top of the address space.
    function automatic logic [ADDR_W-1:0] word_offset(input logic [KW-1:0] idx);
        return ADDR_W'(idx) << WORD_SHIFT;
    endfunction

    assign k_next    = k + KW'(1);
    assign last_beat = (k == LAST_K);
    assign beat_done = mem_req && !mem_wait;

    // Writebacks always store full words.
    assign mem_mask  = '1;

    // mem_addr/mem_wd are registered and only advance on a completed beat,
    // so they stay put for as long as the memory stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_q      <= OP_FILL;
            k         <= '0;
            wb_base   <= '0;
            fill_base <= '0;
            wb_line   <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            fill_line <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wd    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (req_valid && req_ready) begin
                        op_q      <= xfer_op_t'(req_op);
                        wb_base   <= line_align(req_wb_addr);
                        fill_base <= line_align(req_fill_addr);
                        wb_line   <= req_wb_line;
                        k         <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        case (xfer_op_t'(req_op))
                            OP_FILL: begin
                                state    <= ST_FILL;
                                mem_req  <= 1'b1;
                                mem_we   <= 1'b0;
                                mem_addr <= line_align(req_fill_addr);
                            end
                            OP_WB, OP_WB_FILL: begin
                                state    <= ST_WB;
                                mem_req  <= 1'b1;
                                mem_we   <= 1'b1;
                                mem_addr <= line_align(req_wb_addr);
                                mem_wd   <= req_wb_line[DATA_W-1:0];
                            end
                            default: begin
                                // Illegal op: no bus traffic, report straight away.
                                state <= ST_DONE;
                                done  <= 1'b1;
                                err   <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_WB: begin
                    if (beat_done) begin
                        if (last_beat) begin
                            k <= '0;
                            if (op_q == OP_WB_FILL) begin
                                state    <= ST_FILL;
                                mem_we   <= 1'b0;
                                mem_addr <= fill_base;
                            end else begin
                                state   <= ST_DONE;
                                mem_req <= 1'b0;
                                mem_we  <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else begin
                            k        <= k_next;
                            mem_addr <= wb_base + word_offset(k_next);
                            mem_wd   <= wb_line[int'(k_next)*DATA_W +: DATA_W];
                        end
                    end
                end

                ST_FILL: begin
                    if (beat_done) begin
                        fill_line[int'(k)*DATA_W +: DATA_W] <= mem_rd;
                        if (last_beat) begin
                            k       <= '0;
                            state   <= ST_DONE;
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            k        <= k_next;
                            mem_addr <= fill_base + word_offset(k_next);
                        end
                    end
                end

                ST_DONE: begin
                    state     <= ST_IDLE;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end

                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_xfer.sv
// tb/tb_cache_line_xfer.sv - self-checking bench for cache_line_xfer (WORDS=4, DATA_W=32, ADDR_W=32)

module tb_cache_line_xfer;

    localparam int WORDS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic [1:0]    req_op;
    logic [31:0]   req_wb_addr;
    logic [31:0]   req_fill_addr;
    logic [127:0]  req_wb_line;
    logic          req_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [127:0]  fill_line;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wd;
    logic [3:0]    mem_mask;
    logic          mem_wait;
    logic [31:0]   mem_rd;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } beat_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] salt = 32'h0;
    int          wait_mode = 0;
    logic [31:0] hold_addr = 32'h1;
    int          hold_left = 0;
    int          hold_seen = 0;
    int          wait_cnt = 0;
    beat_t       got_q[$];
    logic [127:0] model_fill = '0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr;
    logic [31:0] prev_wd;

    always #5 clk = ~clk;

    // Memory returns the word address XOR a per-test salt.
    assign mem_rd = mem_addr ^ salt;

    cache_line_xfer #(.WORDS(4), .DATA_W(32), .ADDR_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_op        (req_op),
        .req_wb_addr   (req_wb_addr),
        .req_fill_addr (req_fill_addr),
        .req_wb_line   (req_wb_line),
        .req_ready     (req_ready),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .fill_line     (fill_line),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wd        (mem_wd),
        .mem_mask      (mem_mask),
        .mem_wait      (mem_wait),
        .mem_rd        (mem_rd)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stall generator: none, random, or a fixed number of stalls on one address.
    initial begin
        mem_wait = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (wait_mode)
                1: mem_wait = ($urandom_range(0, 2) == 0);
                2: begin
                    if (mem_req && mem_addr == hold_addr && hold_left > 0) begin
                        mem_wait = 1'b1;
                        hold_left--;
                    end else begin
                        mem_wait = 1'b0;
                    end
                end
                default: mem_wait = 1'b0;
            endcase
        end
    end

    // Bus monitor: records completed beats, counts stall cycles, checks stability under stall.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (mem_addr == hold_addr) hold_seen++;
                if (prev_stall) begin
                    chk("stall_addr_stable", mem_addr, prev_addr);
                    chk("stall_wd_stable", mem_wd, prev_wd);
                end
                if (mem_we) chk("wb_mask", mem_mask, 4'hF);
                if (mem_wait) wait_cnt++;
                else got_q.push_back(beat_t'{mem_we, mem_addr, mem_we ? mem_wd : 32'h0});
                prev_stall = mem_wait;
                prev_addr  = mem_addr;
                prev_wd    = mem_wd;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // One request end to end, checked against the bus rules of the transfer.
    task automatic run_req(input logic [1:0] op, input logic [31:0] wb, input logic [31:0] fl,
                           input logic [127:0] line, input bit noise, output int lat);
        beat_t        exp_q[$];
        logic [31:0]  wbb;
        logic [31:0]  flb;
        logic [127:0] exp_fill;
        int           base;
        wbb = wb & 32'hFFFF_FFF0;
        flb = fl & 32'hFFFF_FFF0;
        exp_fill = model_fill;
        if (op == 2'b01 || op == 2'b10)
            for (int i = 0; i < WORDS; i++)
                exp_q.push_back(beat_t'{1'b1, wbb + 32'(4 * i), line[32*i +: 32]});
        if (op == 2'b00 || op == 2'b10)
            for (int i = 0; i < WORDS; i++) begin
                exp_q.push_back(beat_t'{1'b0, flb + 32'(4 * i), 32'h0});
                exp_fill[32*i +: 32] = (flb + 32'(4 * i)) ^ salt;
            end
        base = (op == 2'b11) ? 1 : exp_q.size() + 1;

        chk("ready_before_req", req_ready, 1'b1);
        chk("idle_not_busy", busy, 1'b0);
        req_valid     = 1'b1;
        req_op        = op;
        req_wb_addr   = wb;
        req_fill_addr = fl;
        req_wb_line   = line;
        @(posedge clk);
        #1;
        got_q.delete();
        wait_cnt  = 0;
        hold_seen = 0;
        if (noise) begin
            req_op        = 2'($urandom_range(0, 3));
            req_wb_addr   = $urandom;
            req_fill_addr = $urandom;
            req_wb_line   = {$urandom, $urandom, $urandom, $urandom};
        end else begin
            req_valid = 1'b0;
        end
        lat = 1;
        while (done !== 1'b1 && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        req_valid = 1'b0;

        chk("done_latency", lat, base + wait_cnt);
        chk("err_with_done", err, op == 2'b11);
        chk("busy_at_done", busy, 1'b1);
        chk("bus_idle_at_done", {mem_req, mem_we}, 2'b00);
        chk("beat_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("beat%0d", i), got_q[i], exp_q[i]);
        chk("fill_line", fill_line, exp_fill);
        model_fill = exp_fill;

        @(posedge clk);
        #1;
        chk("done_one_cycle", {done, err}, 2'b00);
        chk("ready_after_done", {req_ready, busy}, 2'b10);
        chk("fill_line_held", fill_line, model_fill);
    endtask

    initial begin
        int lat;
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_op        = 2'b00;
        req_wb_addr   = '0;
        req_fill_addr = '0;
        req_wb_line   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_status", {busy, done, err}, 3'b000);
        chk("rst_bus", {mem_req, mem_we}, 2'b00);
        chk("rst_fill_line", fill_line, 128'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Fill from an unaligned address, memory echoes addresses.
        salt = 32'h0;
        run_req(2'b00, 32'h0, 32'h47, 128'h0, 1'b0, lat);
        chk("fill_done_cycle", lat, 5);
        chk("fill_0x47_line", fill_line, {32'h4C, 32'h48, 32'h44, 32'h40});

        // Writeback-then-fill, issued back-to-back.
        run_req(2'b10, 32'h100, 32'h200, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, lat);
        chk("wbfill_done_cycle", lat, 9);

        // Three stall cycles on beat 2 of a fill.
        wait_mode = 2;
        hold_addr = 32'h48;
        hold_left = 3;
        @(posedge clk);
        #1;
        run_req(2'b00, 32'h0, 32'h47, 128'h0, 1'b0, lat);
        chk("stall_done_cycle", lat, 8);
        chk("stall_addr_cycles", hold_seen, 4);
        wait_mode = 0;
        hold_addr = 32'h1;

        // Illegal op.
        run_req(2'b11, 32'h300, 32'h400, 128'h0, 1'b0, lat);
        chk("illegal_done_cycle", lat, 1);

        // Reset in the middle of a fill at beat 2.
        req_valid     = 1'b1;
        req_op        = 2'b00;
        req_fill_addr = 32'h47;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 10 && mem_addr !== 32'h48; i++) begin
            @(posedge clk);
            #1;
        end
        chk("midfill_reached_beat2", {mem_req, mem_addr}, {1'b1, 32'h48});
        reset = 1'b1;
        #1;
        chk("midrst_bus", {mem_req, mem_we}, 2'b00);
        chk("midrst_status", {done, err, busy}, 3'b000);
        chk("midrst_fill_line", fill_line, 128'h0);
        model_fill = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_ready_after", req_ready, 1'b1);
        chk("midrst_bus_after", mem_req, 1'b0);

        // Line at the top of the address space.
        run_req(2'b00, 32'h0, 32'hFFFF_FFF0, 128'h0, 1'b0, lat);
        chk("wrap_fill_line", fill_line, {32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFF4, 32'hFFFF_FFF0});
        run_req(2'b01, 32'hFFFF_FFFD, 32'h0, {32'hD, 32'hC, 32'hB, 32'hA}, 1'b0, lat);

        // Randomized requests with random stalls and request noise while busy.
        for (int n = 0; n < 30; n++) begin
            salt      = $urandom;
            wait_mode = $urandom_range(0, 1);
            run_req(2'($urandom_range(0, 3)), $urandom, $urandom,
                    {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), lat);
        end
        wait_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
